// File: rtl/mem_arb_pkg.sv
// Shared encodings and widths for the I/D memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int LAT_W    = 3;
    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection and starvation-count update
// for one arbitration slot.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                i_req,
    input  logic                d_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output owner_e              winner,
    output logic                any_req,
    output logic [STARVE_W-1:0] starve_nxt
);

    logic i_forced;

    always_comb begin
        any_req    = i_req | d_req;
        i_forced   = (starve_cnt == STARVE_W'(STARVE_MAX));
        winner     = OWN_D;
        starve_nxt = '0;
        if (i_req && (!d_req || i_forced)) begin
            winner = OWN_I;
        end
        // I lost this slot to D: count it, saturating at the limit
        if (i_req && (winner == OWN_D)) begin
            if (i_forced) begin
                starve_nxt = starve_cnt;
            end else begin
                starve_nxt = starve_cnt + STARVE_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word RAM between fetch (I) and load/store (D);
// one access in flight, response after a fixed memory latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [ADDR_W-1:0] d_pc,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [ADDR_W-1:0] m_pc,
    input  logic [DATA_W-1:0] m_rdata
);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    owner_e              winner;
    logic                any_req;
    logic [STARVE_W-1:0] starve_nxt;
    logic                can_arb;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

    mem_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .i_req     (i_req),
        .d_req     (d_req),
        .starve_cnt(starve_cnt_q),
        .winner    (winner),
        .any_req   (any_req),
        .starve_nxt(starve_nxt)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        we_d         = we_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        can_arb      = (state_q == ST_IDLE);
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        i_rvalid     = 1'b0;
        d_rvalid     = 1'b0;
        m_en         = 1'b0;
        m_we         = 1'b0;
        m_addr       = '0;
        m_wdata      = '0;
        m_pc         = '0;

        if (state_q == ST_BUSY) begin
            if (lat_cnt_q == '0) begin
                // response cycle doubles as the next arbitration slot
                can_arb = 1'b1;
                state_d = ST_IDLE;
                if (owner_q == OWN_I) begin
                    i_rvalid  = 1'b1;
                    i_rdata_d = m_rdata;
                end else begin
                    d_rvalid = 1'b1;
                    if (!we_q) begin
                        d_rdata_d = m_rdata;
                    end
                end
            end else begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
        end

        if (can_arb) begin
            starve_cnt_d = starve_nxt;
            if (any_req) begin
                owner_d   = winner;
                state_d   = ST_BUSY;
                lat_cnt_d = LAT_W'(MEM_LAT - 1);
                m_en      = 1'b1;
                if (winner == OWN_I) begin
                    i_gnt  = 1'b1;
                    we_d   = 1'b0;
                    m_addr = {i_addr[ADDR_W-1:2], 2'b00};
                end else begin
                    d_gnt   = 1'b1;
                    we_d    = d_we;
                    m_we    = d_we;
                    m_addr  = {d_addr[ADDR_W-1:2], 2'b00};
                    m_wdata = d_wdata;
                    m_pc    = d_pc;
                end
            end
        end

        if (!rstn) begin
            i_gnt    = 1'b0;
            d_gnt    = 1'b0;
            i_rvalid = 1'b0;
            d_rvalid = 1'b0;
            m_en     = 1'b0;
            m_we     = 1'b0;
        end
    end

    assign i_rdata = rstn ? i_rdata_d : '0;
    assign d_rdata = rstn ? d_rdata_d : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            we_q         <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            we_q         <= we_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 and 3),
// transaction-level reference model, directed and random traffic.
module tb_mem_port_arbiter;

    localparam int STARVE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        int          gap;
        bit          wd;
    } req_t;

    typedef struct {
        int          due;
        bit          own;
        bit          we;
        logic [31:0] data;
    } pend_t;

    typedef struct {
        int          cyc;
        bit          own;
        bit          we;
        logic [31:0] addr;
        logic [31:0] pc;
    } glog_t;

    typedef struct {
        int          cyc;
        bit          own;
        logic [31:0] data;
    } rlog_t;

    task automatic chk(input int g, input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL u%0d %s: got 0x%08h want 0x%08h at %0t",
                     g, nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input int g, input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL u%0d %s: no grant within bound at %0t",
                 g, nm, $time);
    endtask

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 4) return 32'hDEADBEEF;
        return (32'(idx) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        rstn;
        logic        i_req, i_gnt, i_rvalid;
        logic        d_req, d_we, d_gnt, d_rvalid;
        logic        m_en, m_we;
        logic [31:0] i_addr, i_rdata;
        logic [31:0] d_addr, d_wdata, d_pc, d_rdata;
        logic [31:0] m_addr, m_wdata, m_pc, m_rdata;
        bit          fin = 1'b0;

        mem_port_arbiter #(
            .ADDR_W    (32),
            .DATA_W    (32),
            .MEM_LAT   (LAT),
            .STARVE_MAX(STARVE)
        ) dut (
            .clk     (clk),
            .rstn    (rstn),
            .i_req   (i_req),
            .i_addr  (i_addr),
            .i_gnt   (i_gnt),
            .i_rvalid(i_rvalid),
            .i_rdata (i_rdata),
            .d_req   (d_req),
            .d_we    (d_we),
            .d_addr  (d_addr),
            .d_wdata (d_wdata),
            .d_pc    (d_pc),
            .d_gnt   (d_gnt),
            .d_rvalid(d_rvalid),
            .d_rdata (d_rdata),
            .m_en    (m_en),
            .m_we    (m_we),
            .m_addr  (m_addr),
            .m_wdata (m_wdata),
            .m_pc    (m_pc),
            .m_rdata (m_rdata)
        );

        // RAM with a LAT-deep read pipeline
        logic [31:0] ram [int];
        logic [31:0] pipe [8];

        always @(posedge clk) begin : env
            logic [31:0] rd;
            int          idx;
            idx = int'(m_addr[7:2]);
            rd  = ram.exists(idx) ? ram[idx] : init_word(idx);
            if (m_en && m_we) ram[idx] = m_wdata;
            pipe[0] <= rd;
            for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
        end

        assign m_rdata = pipe[LAT-1];

        // Reference model: slots, pending responses, golden memory
        int          cyc = 0;
        int          next_free = 0;
        int          lost = 0;
        pend_t       pq[$];
        logic [31:0] gram [int];
        logic [31:0] e_ir = 0;
        logic [31:0] e_dr = 0;
        glog_t       glog[$];
        rlog_t       rlog[$];

        always @(negedge clk) begin : model
            bit          e_ig, e_dg, e_iv, e_dv, e_en, e_we;
            logic [31:0] e_addr, e_wd, e_pc, w;
            pend_t       p;
            int          idx;
            e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0;
            e_en = 0; e_we = 0;
            e_addr = 0; e_wd = 0; e_pc = 0;
            if (!rstn) begin
                pq.delete();
                next_free = cyc + 1;
                lost = 0;
                e_ir = 0;
                e_dr = 0;
            end else begin
                if (pq.size() > 0 && pq[0].due == cyc) begin
                    p = pq.pop_front();
                    if (!p.own) begin
                        e_iv = 1;
                        e_ir = p.data;
                    end else begin
                        e_dv = 1;
                        if (!p.we) e_dr = p.data;
                    end
                end
                if (cyc >= next_free) begin
                    if (i_req && (!d_req || lost == STARVE)) begin
                        e_ig = 1;
                        lost = 0;
                        e_addr = i_addr & ~32'h3;
                    end else if (d_req) begin
                        e_dg = 1;
                        lost = i_req ? lost + 1 : 0;
                        e_addr = d_addr & ~32'h3;
                        e_we = d_we;
                        e_wd = d_wdata;
                        e_pc = d_pc;
                    end else begin
                        lost = 0;
                    end
                    if (e_ig || e_dg) begin
                        e_en = 1;
                        idx = int'(e_addr[7:2]);
                        w = gram.exists(idx) ? gram[idx]
                                             : init_word(idx);
                        pq.push_back('{cyc + LAT, e_dg, e_we, w});
                        if (e_we) gram[idx] = e_wd;
                        next_free = cyc + LAT;
                    end
                end
            end
            chk(g, "i_gnt", i_gnt, e_ig);
            chk(g, "d_gnt", d_gnt, e_dg);
            chk(g, "m_en", m_en, e_en);
            chk(g, "m_we", m_we, e_we);
            chk(g, "i_rvalid", i_rvalid, e_iv);
            chk(g, "d_rvalid", d_rvalid, e_dv);
            chk(g, "i_rdata", i_rdata, e_ir);
            chk(g, "d_rdata", d_rdata, e_dr);
            if (e_en) begin
                chk(g, "m_addr", m_addr, e_addr);
                chk(g, "m_pc", m_pc, e_pc);
            end
            if (e_we) chk(g, "m_wdata", m_wdata, e_wd);
            if (rstn && (i_gnt || d_gnt))
                glog.push_back('{cyc, d_gnt, m_we, m_addr, m_pc});
            if (rstn && (i_rvalid || d_rvalid))
                rlog.push_back('{cyc, d_rvalid,
                                 d_rvalid ? d_rdata : i_rdata});
            cyc++;
        end

        req_t iq[$];
        req_t dq[$];

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic wait_i(input bit wd);
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if ((rstn && i_gnt) || wd) begin
                    step();
                    i_req = 0;
                    return;
                end
                step();
            end
            tmo(g, "i_timeout");
            i_req = 0;
        endtask

        task automatic wait_d();
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (rstn && d_gnt) begin
                    step();
                    d_req = 0;
                    return;
                end
                step();
            end
            tmo(g, "d_timeout");
            d_req = 0;
        endtask

        task automatic i_agent();
            req_t r;
            while (iq.size() > 0) begin
                r = iq.pop_front();
                repeat (r.gap) step();
                i_req  = 1;
                i_addr = r.addr;
                wait_i(r.wd);
            end
        endtask

        task automatic d_agent();
            req_t r;
            while (dq.size() > 0) begin
                r = dq.pop_front();
                repeat (r.gap) step();
                d_req   = 1;
                d_we    = r.we;
                d_addr  = r.addr;
                d_wdata = r.wdata;
                d_pc    = r.pc;
                wait_d();
            end
        endtask

        task automatic run();
            fork
                i_agent();
                d_agent();
            join
        endtask

        task automatic clr();
            glog.delete();
            rlog.delete();
        endtask

        initial begin : ctl
            int     rel;
            int     nd;
            bit [9:0] ord;
            req_t   r;
            rstn = 0;
            i_req = 0; i_addr = 0;
            d_req = 0; d_we = 0; d_addr = 0;
            d_wdata = 0; d_pc = 0;
            repeat (3) step();
            rstn = 1;
            step();
            if (LAT == 1) begin
                // single load of the DEADBEEF word
                clr();
                dq.push_back('{0, 32'h10, 0, 32'h100, 0, 0});
                run();
                repeat (3) step();
                chk(g, "t1_ngnt", glog.size(), 1);
                chk(g, "t1_nrv", rlog.size(), 1);
                if (glog.size() >= 1 && rlog.size() >= 1) begin
                    chk(g, "t1_own", glog[0].own, 1);
                    chk(g, "t1_addr", glog[0].addr, 32'h10);
                    chk(g, "t1_lat", rlog[0].cyc - glog[0].cyc, 1);
                    chk(g, "t1_data", rlog[0].data, 32'hDEADBEEF);
                end
                // both requesters saturated
                clr();
                for (int k = 0; k < 10; k++) begin
                    iq.push_back('{0, 32'(8 * k), 0, 0, 0, 0});
                    dq.push_back('{0, 32'(4 * k + 64), 0,
                                   32'(k), 0, 0});
                end
                run();
                repeat (3) step();
                chk(g, "t2_ngnt", glog.size(), 20);
                ord = '0;
                if (glog.size() >= 10) begin
                    for (int k = 0; k < 10; k++)
                        ord = {ord[8:0], glog[k].own};
                    chk(g, "t2_order", 32'(ord), 32'b11110_11110);
                end
                // store then misaligned load of the same word
                clr();
                dq.push_back('{1, 32'h20, 32'h12345678, 32'h400, 0, 0});
                dq.push_back('{0, 32'h23, 0, 32'h404, 0, 0});
                run();
                repeat (3) step();
                chk(g, "t3_ngnt", glog.size(), 2);
                chk(g, "t3_nrv", rlog.size(), 2);
                if (glog.size() >= 2 && rlog.size() >= 2) begin
                    chk(g, "t3_st_we", glog[0].we, 1);
                    chk(g, "t3_st_pc", glog[0].pc, 32'h400);
                    chk(g, "t3_ld_addr", glog[1].addr, 32'h20);
                    chk(g, "t3_ld_data", rlog[1].data, 32'h12345678);
                end
            end else begin
                // back-to-back fetches at latency 3
                clr();
                iq.push_back('{0, 32'h0, 0, 0, 0, 0});
                iq.push_back('{0, 32'h4, 0, 0, 0, 0});
                run();
                repeat (5) step();
                chk(g, "t4_ngnt", glog.size(), 2);
                chk(g, "t4_nrv", rlog.size(), 2);
                if (glog.size() >= 2 && rlog.size() >= 2) begin
                    chk(g, "t4_gap", glog[1].cyc - glog[0].cyc, 3);
                    chk(g, "t4_lat0", rlog[0].cyc - glog[0].cyc, 3);
                    chk(g, "t4_lat1", rlog[1].cyc - glog[1].cyc, 3);
                    chk(g, "t4_d0", rlog[0].data, 32'h5A5A0000);
                    chk(g, "t4_d1", rlog[1].data, 32'h5B5B0101);
                end
                // fetch request withdrawn while a load is busy
                clr();
                dq.push_back('{0, 32'h10, 0, 32'h200, 0, 0});
                iq.push_back('{0, 32'h8, 0, 0, 1, 1});
                run();
                repeat (5) step();
                chk(g, "t6_ngnt", glog.size(), 1);
                if (glog.size() >= 1)
                    chk(g, "t6_own", glog[0].own, 1);
                // reset one cycle after a load grant
                dq.push_back('{0, 32'h14, 0, 32'h300, 0, 0});
                run();
                clr();
                rstn = 0;
                i_req = 1;
                i_addr = 32'h18;
                step();
                rstn = 1;
                rel = cyc;
                wait_i(0);
                repeat (6) step();
                nd = 0;
                foreach (rlog[k]) if (rlog[k].own) nd++;
                chk(g, "t5_no_drv", nd, 0);
                chk(g, "t5_ngnt", glog.size(), 1);
                if (glog.size() >= 1) begin
                    chk(g, "t5_own", glog[0].own, 0);
                    chk(g, "t5_cyc", glog[0].cyc, rel);
                end
            end
            // random mixed traffic
            for (int k = 0; k < 40; k++) begin
                r.we    = 0;
                r.addr  = $urandom_range(0, 255);
                r.wdata = 0;
                r.pc    = 0;
                r.gap   = $urandom_range(0, 3);
                r.wd    = ($urandom_range(0, 9) == 0);
                iq.push_back(r);
                r.we    = $urandom_range(0, 1);
                r.addr  = $urandom_range(0, 255);
                r.wdata = $urandom;
                r.pc    = $urandom;
                r.gap   = $urandom_range(0, 3);
                r.wd    = 0;
                dq.push_back(r);
            end
            run();
            repeat (8) step();
            fin = 1;
        end
    end

    initial begin : top
        int k;
        k = 0;
        while (!(u[0].fin && u[1].fin) && k < 20000) begin
            @(posedge clk);
            k++;
        end
        if (!(u[0].fin && u[1].fin)) begin
            n_chk++;
            n_fail++;
            $display("FAIL global_timeout: bench did not finish");
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
